// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite draw engine.
// Fetches N sprite bytes from RAM at I, then XORs each one into the 64x32 1-bpp VRAM.
// Each sprite row touches at most two VRAM bytes: left and right.
// VF collision is accumulated as a sticky flag.
// This block is the sole master of the memory video request port.
`timescale 1ns/1ps
module chip8_sprite_draw #(
  parameter int WIDTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [3:0]  n_in,
  input  logic [11:0] i_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        collision_out,
  output logic [15:0] video_addr_out,
  output logic        video_we_out,
  output logic        video_valid_out,
  output logic [15:0] video_data_out,
  output logic        video_type_out,
  input  logic        video_ready_in,
  input  logic        video_valid_in,
  input  logic [15:0] mem_data_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_SPR_REQ, S_SPR_WAIT, S_L_REQ, S_L_WAIT, S_L_WR,
    S_R_REQ, S_R_WAIT, S_R_WR, S_NEXT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       x0_q, x0_d;
  logic [4:0]       y0_q, y0_d;
  logic [3:0]       n_q, n_d;
  logic [11:0]      i_q, i_d;
  logic [4:0]       r_q, r_d;
  logic [WIDTH-1:0] ml_q, ml_d, mr_q, mr_d, old_q, old_d;
  logic             coll_q, coll_d;

  // Upper input bits are don't-care: start position wraps, data is one byte.
  logic unused_bits;
  assign unused_bits = ^{x_in[7:6], y_in[7:5], mem_data_in[15:WIDTH]};

  logic                 accept;
  logic [5:0]           row_sum, next_row;
  logic [4:0]           r_inc;
  logic [7:0]           bl, br;
  logic                 right_ok, last_row;
  logic [2*WIDTH-1:0]   m16;
  logic [WIDTH-1:0]     rd_byte;

  assign accept   = video_valid_out & video_ready_in;
  assign rd_byte  = mem_data_in[WIDTH-1:0];
  // Row never exceeds 31 here because NEXT clips at the bottom edge.
  assign row_sum  = {1'b0, y0_q} + {1'b0, r_q};
  assign next_row = row_sum + 6'd1;
  assign r_inc    = r_q + 5'd1;
  assign bl       = {row_sum[4:0], x0_q[5:3]};
  // The right byte is never fetched in column 7, so bl+1 stays within the row.
  assign br       = bl + 8'd1;
  assign right_ok = (mr_q != '0) && (x0_q[5:3] != 3'd7);
  assign last_row = (r_inc == {1'b0, n_q}) || (next_row >= 6'd32);
  assign m16      = {rd_byte, {WIDTH{1'b0}}} >> x0_q[2:0];

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      n_q     <= '0;
      i_q     <= '0;
      r_q     <= '0;
      ml_q    <= '0;
      mr_q    <= '0;
      old_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      n_q     <= n_d;
      i_q     <= i_d;
      r_q     <= r_d;
      ml_q    <= ml_d;
      mr_q    <= mr_d;
      old_q   <= old_d;
      coll_q  <= coll_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_in) state_d = (n_in == 4'd0) ? S_DONE : S_SPR_REQ;
      S_SPR_REQ:  if (accept) state_d = S_SPR_WAIT;
      S_SPR_WAIT: if (video_valid_in) state_d = S_L_REQ;
      S_L_REQ: begin
        if (ml_q == '0)  state_d = right_ok ? S_R_REQ : S_NEXT;
        else if (accept) state_d = S_L_WAIT;
      end
      S_L_WAIT:   if (video_valid_in) state_d = S_L_WR;
      S_L_WR:     if (accept) state_d = right_ok ? S_R_REQ : S_NEXT;
      S_R_REQ:    if (accept) state_d = S_R_WAIT;
      S_R_WAIT:   if (video_valid_in) state_d = S_R_WR;
      S_R_WR:     if (accept) state_d = S_NEXT;
      S_NEXT:     state_d = last_row ? S_DONE : S_SPR_REQ;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch command, capture masks and old VRAM bytes, sticky collision
  always_comb begin
    x0_d   = x0_q;
    y0_d   = y0_q;
    n_d    = n_q;
    i_d    = i_q;
    r_d    = r_q;
    ml_d   = ml_q;
    mr_d   = mr_q;
    old_d  = old_q;
    coll_d = coll_q;
    case (state_q)
      S_IDLE: if (start_in) begin
        x0_d   = x_in[5:0];
        y0_d   = y_in[4:0];
        n_d    = n_in;
        i_d    = i_in;
        r_d    = '0;
        coll_d = 1'b0;
      end
      S_SPR_WAIT: if (video_valid_in) begin
        ml_d = m16[2*WIDTH-1:WIDTH];
        mr_d = m16[WIDTH-1:0];
      end
      S_L_WAIT: if (video_valid_in) begin
        old_d = rd_byte;
        if ((rd_byte & ml_q) != '0) coll_d = 1'b1;
      end
      S_R_WAIT: if (video_valid_in) begin
        old_d = rd_byte;
        if ((rd_byte & mr_q) != '0) coll_d = 1'b1;
      end
      S_NEXT: r_d = r_inc;
      default: ;
    endcase
  end

  // Outputs decoded from state; request fields depend only on held registers, so they stay stable under backpressure
  always_comb begin
    video_valid_out = 1'b0;
    video_we_out    = 1'b0;
    video_type_out  = 1'b0;
    video_addr_out  = '0;
    video_data_out  = '0;
    done_out        = 1'b0;
    busy_out        = (state_q != S_IDLE) && (state_q != S_DONE);
    case (state_q)
      S_SPR_REQ: begin
        video_valid_out = 1'b1;
        video_addr_out  = {4'h0, i_q + {7'd0, r_q}};
      end
      S_L_REQ: begin
        video_valid_out = (ml_q != '0);
        video_type_out  = 1'b1;
        video_addr_out  = {8'h00, bl};
      end
      S_L_WR: begin
        video_valid_out = 1'b1;
        video_we_out    = 1'b1;
        video_type_out  = 1'b1;
        video_addr_out  = {8'h00, bl};
        video_data_out  = {{(16-WIDTH){1'b0}}, old_q ^ ml_q};
      end
      S_R_REQ: begin
        video_valid_out = 1'b1;
        video_type_out  = 1'b1;
        video_addr_out  = {8'h00, br};
      end
      S_R_WR: begin
        video_valid_out = 1'b1;
        video_we_out    = 1'b1;
        video_type_out  = 1'b1;
        video_addr_out  = {8'h00, br};
        video_data_out  = {{(16-WIDTH){1'b0}}, old_q ^ mr_q};
      end
      S_DONE: done_out = 1'b1;
      default: ;
    endcase
  end

  assign collision_out = coll_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Scoreboard bench for chip8_sprite_draw: pixel-level reference model, RAM/VRAM responder, random ready and latency.
`timescale 1ns/1ps
module tb_chip8_sprite_draw;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic [7:0]  x_in = '0, y_in = '0;
  logic [3:0]  n_in = '0;
  logic [11:0] i_in = '0;
  logic        busy_out, done_out, collision_out;
  logic [15:0] video_addr_out, video_data_out;
  logic        video_we_out, video_valid_out, video_type_out;
  logic        video_ready_in = 1'b0, video_valid_in = 1'b0;
  logic [15:0] mem_data_in = '0;

  always #5 clk = ~clk;

  chip8_sprite_draw #(.WIDTH(8)) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_in),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
    .busy_out(busy_out), .done_out(done_out), .collision_out(collision_out),
    .video_addr_out(video_addr_out), .video_we_out(video_we_out),
    .video_valid_out(video_valid_out), .video_data_out(video_data_out),
    .video_type_out(video_type_out), .video_ready_in(video_ready_in),
    .video_valid_in(video_valid_in), .mem_data_in(mem_data_in));

  typedef struct { logic we; logic typ; logic [15:0] addr; logic [7:0] data; } req_t;
  req_t exp_q[$];
  bit   coll_q[$];
  int   errors = 0, checks = 0;
  logic [7:0] mem_ram [4096];
  logic [7:0] mem_vram[256];
  logic [7:0] ref_v   [256];
  logic [7:0] saved_v [256];
  int   rd_tag = 0;
  logic [7:0] rd_data = '0;
  int   bp_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit pix(input int col, input int row);
    logic [7:0] b;
    b = ref_v[row*8 + col/8];
    return b[7 - col%8];
  endfunction

  task automatic flip(input int col, input int row);
    logic [7:0] b;
    b = ref_v[row*8 + col/8];
    b[7 - col%8] = ~b[7 - col%8];
    ref_v[row*8 + col/8] = b;
  endtask

  // Reference: pixel-by-pixel sprite XOR with clipping, emitting the expected bus transactions.
  task automatic ref_draw(input int x, input int y, input int n, input int i);
    int x0, y0;
    bit coll;
    logic [7:0] spr;
    req_t t;
    x0 = x % 64; y0 = y % 32; coll = 0;
    for (int r = 0; r < n && y0 + r < 32; r++) begin
      int a, row;
      a = (i + r) % 4096; row = y0 + r;
      spr = mem_ram[a];
      t.we = 0; t.typ = 0; t.addr = 16'(a); t.data = '0;
      exp_q.push_back(t);
      for (int side = 0; side < 2; side++) begin
        int bcol;
        logic [7:0] mask;
        bcol = x0/8 + side;
        mask = '0;
        if (bcol > 7) continue;
        for (int b = 0; b < 8; b++)
          if (spr[7-b] && (x0 + b)/8 == bcol) mask[7 - (x0 + b)%8] = 1'b1;
        if (mask == 0) continue;
        t.we = 0; t.typ = 1; t.addr = 16'(row*8 + bcol); t.data = '0;
        exp_q.push_back(t);
        for (int c = bcol*8; c < bcol*8 + 8; c++)
          if (mask[7 - c%8]) begin
            if (pix(c, row)) coll = 1;
            flip(c, row);
          end
        t.we = 1; t.data = ref_v[row*8 + bcol];
        exp_q.push_back(t);
      end
    end
    coll_q.push_back(coll);
  endtask

  // Monitor: score accepted requests and done pulses; act as the memory for accepted requests.
  initial begin
    logic pv, pw, pt;
    logic [15:0] pa, pd;
    req_t t;
    pv = 0; pw = 0; pt = 0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (pv && video_valid_out)
        chk("hold_stable", {video_addr_out, video_data_out, video_we_out, video_type_out},
                           {pa, pd, pw, pt});
      pv = video_valid_out && !video_ready_in;
      pa = video_addr_out; pd = video_data_out; pw = video_we_out; pt = video_type_out;
      if (video_valid_out && video_ready_in) begin
        if (exp_q.size() == 0) chk("unexpected_req", video_addr_out, 32'hFFFFFFFF);
        else begin
          t = exp_q.pop_front();
          chk("req_kind", {video_we_out, video_type_out}, {t.we, t.typ});
          chk("req_addr", video_addr_out, t.addr);
          if (t.we) chk("wr_data", video_data_out, {8'h00, t.data});
        end
        if (video_we_out) begin
          if (video_type_out) mem_vram[video_addr_out[7:0]] = video_data_out[7:0];
        end else begin
          rd_data = video_type_out ? mem_vram[video_addr_out[7:0]] : mem_ram[video_addr_out[11:0]];
          rd_tag++;
        end
      end
      if (done_out) begin
        if (coll_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("collision", collision_out, coll_q.pop_front());
      end
    end
  end

  // Responder: random ready, optional forced backpressure, read data after 3..5 cycles with junk upper bits.
  initial begin
    int seen, lat, bp_seen, bp_cnt;
    bit pend;
    seen = 0; lat = 0; bp_seen = 0; bp_cnt = 0; pend = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_req != bp_seen && video_valid_out) begin bp_seen = bp_req; bp_cnt = 5; end
      if (bp_cnt > 0) begin video_ready_in = 1'b0; bp_cnt--; end
      else video_ready_in = ($urandom_range(0, 3) != 0);
      video_valid_in = 1'b0;
      if (rd_tag != seen) begin seen = rd_tag; lat = $urandom_range(2, 4); pend = 1; end
      else if (pend) begin
        if (lat == 0) begin
          video_valid_in = 1'b1;
          mem_data_in = {8'($urandom), rd_data};
          pend = 0;
        end else lat--;
      end
    end
  end

  task automatic draw(input int x, input int y, input int n, input int i);
    int cyc;
    ref_draw(x, y, n, i);
    start_in = 1'b1; x_in = 8'(x); y_in = 8'(y); n_in = 4'(n); i_in = 12'(i);
    @(posedge clk); #1 start_in = 1'b0;
    @(negedge clk);
    if (n == 0) chk("n0_done_next", {done_out, busy_out, video_valid_out}, 3'b100);
    else        chk("busy_after_start", {busy_out, done_out}, 2'b10);
    cyc = 0;
    while (!done_out && cyc < 3000) begin @(negedge clk); cyc++; end
    if (!done_out) chk("draw_timeout", cyc, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, mism;
    for (int k = 0; k < 4096; k++) mem_ram[k] = 8'($urandom);
    for (int k = 0; k < 256; k++) begin mem_vram[k] = '0; ref_v[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy_out, done_out, collision_out, video_valid_out, video_we_out,
                          video_type_out, video_addr_out, video_data_out}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // aligned draw, no collision
    mem_ram[12'h050] = 8'hF0;
    draw(0, 0, 1, 12'h050);
    chk("aligned_vram0", mem_vram[0], 8'hF0);
    chk("aligned_coll", collision_out, 0);

    // straddle with collision
    mem_vram[0] = '0; ref_v[0] = '0; mem_vram[1] = 8'h80; ref_v[1] = 8'h80;
    mem_ram[12'h060] = 8'hFF;
    draw(4, 0, 1, 12'h060);
    chk("straddle_vram0", mem_vram[0], 8'h0F);
    chk("straddle_vram1", mem_vram[1], 8'h70);
    chk("straddle_coll", collision_out, 1);

    // right and bottom clipping
    for (int k = 0; k < 5; k++) mem_ram[12'h100 + k] = 8'hFF;
    draw(60, 30, 5, 12'h100);
    chk("clip_247", mem_vram[247], 8'h0F);
    chk("clip_255", mem_vram[255], 8'h0F);
    chk("clip_no_wrap_col0", mem_vram[240], 8'h00);

    // start wrap: the wrapped position redraws the same pixels and erases them
    mem_ram[12'h200] = 8'hC3; mem_ram[12'h201] = 8'h5A;
    draw(70, 40, 2, 12'h200);
    draw(6, 8, 2, 12'h200);
    chk("wrap_erase", {mem_vram[64], mem_vram[65], mem_vram[72], mem_vram[73]}, '0);
    chk("wrap_coll", collision_out, 1);

    // zero height
    draw(5, 5, 0, 12'h123);

    // I wrap with forced backpressure
    mem_ram[12'hFFF] = 8'h81; mem_ram[12'h000] = 8'h3C;
    bp_req++;
    draw(10, 3, 2, 12'hFFF);

    // reset while waiting for left VRAM read data
    saved_v = ref_v;
    mem_ram[12'h300] = 8'hAA;
    ref_draw(0, 0, 1, 12'h300);
    start_in = 1'b1; x_in = '0; y_in = '0; n_in = 4'd1; i_in = 12'h300;
    @(posedge clk); #1 start_in = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end
    while (!(video_valid_out && video_ready_in && video_type_out && !video_we_out) && cyc < 500);
    if (cyc >= 500) chk("rst_wait_timeout", cyc, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_draw", {busy_out, video_valid_out}, 2'b00);
    exp_q.delete(); coll_q.delete(); ref_v = saved_v;
    repeat (12) @(negedge clk);
    chk("late_rsp_ignored", {busy_out, video_valid_out, done_out}, 3'b000);
    @(posedge clk); #1;
    draw(0, 0, 1, 12'h300);

    // random draws
    for (int k = 0; k < 25; k++)
      draw($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 4095));

    chk("queues_drained", {16'(exp_q.size()), 16'(coll_q.size())}, 0);
    mism = 0;
    for (int k = 0; k < 256; k++) if (mem_vram[k] !== ref_v[k]) mism++;
    chk("vram_final", mism, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "timeout");
  end
endmodule
